// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the round-robin Alu arbiter and the Alu itself.
package alu_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned OP_W    = 3;

    // Alu opcodes; 3'b011 and 3'b111 have no defined operation
    localparam logic [OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [OP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [OP_W-1:0] ALU_NOR = 3'b100;
    localparam logic [OP_W-1:0] ALU_XOR = 3'b101;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } arb_state_t;

    // True when the opcode maps to a real Alu operation
    function automatic logic alu_op_legal(input logic [OP_W-1:0] op);
        return (op == ALU_AND) || (op == ALU_OR)  || (op == ALU_ADD) ||
               (op == ALU_NOR) || (op == ALU_XOR) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational Alu: logic ops, add/sub with signed overflow, less-than compare.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [OP_W-1:0] op,
    input  logic            unsig,
    output logic [DW-1:0]   aluout,
    output logic            compout,
    output logic            overflow
);

    logic [DW-1:0] sum_c;
    logic [DW-1:0] diff_c;

    assign sum_c  = a + b;
    assign diff_c = a - b;

    // Result mux; overflow is two's-complement overflow of add/sub only
    always_comb begin
        aluout   = '0;
        overflow = 1'b0;
        case (op)
            ALU_AND: aluout = a & b;
            ALU_OR:  aluout = a | b;
            ALU_NOR: aluout = ~(a | b);
            ALU_XOR: aluout = a ^ b;
            ALU_ADD: begin
                aluout   = sum_c;
                overflow = (a[DW-1] == b[DW-1]) && (sum_c[DW-1] != a[DW-1]);
            end
            ALU_SUB: begin
                aluout   = diff_c;
                overflow = (a[DW-1] != b[DW-1]) && (diff_c[DW-1] != a[DW-1]);
            end
            default: aluout = '0;
        endcase
    end

    // a < b, unsigned or signed depending on unsig
    assign compout = unsig ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; prio breaks ties only.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       win_c,
    output logic       valid_c
);

    // A lone requester always wins; prio decides only under contention
    always_comb begin
        win_c = prio;
        case (req)
            2'b01:   win_c = 1'b0;
            2'b10:   win_c = 1'b1;
            default: win_c = prio;
        endcase
    end

    assign valid_c = |req;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one Alu between two requesters with round-robin arbitration.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned RR_INIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic              unsig0,
    input  logic              unsig1,
    input  logic [DW-1:0]     a0,
    input  logic [DW-1:0]     a1,
    input  logic [DW-1:0]     b0,
    input  logic [DW-1:0]     b1,
    output logic [1:0]        gnt,
    output logic [1:0]        rsp_valid,
    output logic [DW-1:0]     rsp_result,
    output logic              rsp_compout,
    output logic              rsp_overflow,
    output logic              rsp_err
);

    arb_state_t      state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_result_q, rsp_result_d;
    logic            rsp_compout_q, rsp_compout_d;
    logic            rsp_overflow_q, rsp_overflow_d;
    logic            rsp_err_q, rsp_err_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic            alu_unsig_q, alu_unsig_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic            owner_q, owner_d;
    logic            prio_q, prio_d;
    logic            err_q, err_d;

    logic            win_c;
    logic            arb_valid_c;
    logic [OP_W-1:0] sel_op_c;
    logic            sel_unsig_c;
    logic [DW-1:0]   sel_a_c;
    logic [DW-1:0]   sel_b_c;
    logic            sel_legal_c;
    logic [DW-1:0]   aluout_c;
    logic            compout_c;
    logic            overflow_c;

    rr_arb2 u_arb (
        .req     (req),
        .prio    (prio_q),
        .win_c   (win_c),
        .valid_c (arb_valid_c)
    );

    alu #(.DW(DW)) u_alu (
        .a        (alu_a_q),
        .b        (alu_b_q),
        .op       (alu_op_q),
        .unsig    (alu_unsig_q),
        .aluout   (aluout_c),
        .compout  (compout_c),
        .overflow (overflow_c)
    );

    // Winner's request fields
    always_comb begin
        sel_op_c    = win_c ? op1    : op0;
        sel_unsig_c = win_c ? unsig1 : unsig0;
        sel_a_c     = win_c ? a1     : a0;
        sel_b_c     = win_c ? b1     : b0;
        sel_legal_c = alu_op_legal(sel_op_c);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        gnt_d          = 2'b00;
        rsp_valid_d    = 2'b00;
        rsp_result_d   = rsp_result_q;
        rsp_compout_d  = rsp_compout_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        alu_op_d       = alu_op_q;
        alu_unsig_d    = alu_unsig_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        owner_d        = owner_q;
        prio_d         = prio_q;
        err_d          = err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid_c) begin
                    // Illegal ops park the Alu on all-zero inputs
                    alu_op_d    = sel_legal_c ? sel_op_c    : ALU_AND;
                    alu_unsig_d = sel_legal_c ? sel_unsig_c : 1'b0;
                    alu_a_d     = sel_legal_c ? sel_a_c     : '0;
                    alu_b_d     = sel_legal_c ? sel_b_c     : '0;
                    err_d       = ~sel_legal_c;
                    owner_d     = win_c;
                    gnt_d       = win_c ? 2'b10 : 2'b01;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d   = err_q ? '0   : aluout_c;
                rsp_compout_d  = err_q ? 1'b0 : compout_c;
                rsp_overflow_d = err_q ? 1'b0 : overflow_c;
                rsp_err_d      = err_q;
                rsp_valid_d    = owner_q ? 2'b10 : 2'b01;
                prio_d         = ~owner_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            gnt_q          <= 2'b00;
            rsp_valid_q    <= 2'b00;
            rsp_result_q   <= '0;
            rsp_compout_q  <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            alu_op_q       <= '0;
            alu_unsig_q    <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            owner_q        <= 1'b0;
            prio_q         <= 1'(RR_INIT);
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_compout_q  <= rsp_compout_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
            alu_op_q       <= alu_op_d;
            alu_unsig_q    <= alu_unsig_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            owner_q        <= owner_d;
            prio_q         <= prio_d;
            err_q          <= err_d;
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_compout  = rsp_compout_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner sequences, random vs model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic        unsig0 = 1'b0, unsig1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [1:0]  gnt, rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_compout, rsp_overflow, rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  req;
        logic [2:0]  op0, op1;
        logic        u0, u1;
        logic [31:0] a0, b0, a1, b1;
        logic [1:0]  gnt;
        logic [31:0] res;
        logic        comp, ovf, err;
    } vec_t;

    alu_arbiter #(.DW(32), .RR_INIT(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .op0(op0), .op1(op1), .unsig0(unsig0), .unsig1(unsig1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_compout(rsp_compout), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference Alu behaviour from the operation definitions, using wide arithmetic
    function automatic void model(input logic [2:0] op, input logic u,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic comp,
                                  output logic ovf, output logic err);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s = 0;
        res = 0; ovf = 0; comp = 0;
        err = !(op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd6);
        if (!err) begin
            case (op)
                3'd0: res = a & b;
                3'd1: res = a | b;
                3'd4: res = ~(a | b);
                3'd5: res = a ^ b;
                3'd2: s = sa + sb;
                3'd6: s = sa - sb;
                default: res = 0;
            endcase
            if (op == 3'd2 || op == 3'd6) begin
                res = 32'(s);
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            comp = u ? (a < b) : (sa < sb);
        end
    endfunction

    // One full transaction: drive, expect grant next cycle, response the cycle after
    task automatic run_op(input vec_t v, input string tag);
        req = v.req; op0 = v.op0; op1 = v.op1; unsig0 = v.u0; unsig1 = v.u1;
        a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
        @(posedge clk); #1;
        check({tag, ".gnt"}, 32'(gnt), 32'(v.gnt));
        check({tag, ".no_rsp_in_gnt"}, 32'(rsp_valid), 32'd0);
        if (v.err) begin
            check({tag, ".alu_in_zero"},
                  32'(dut.alu_a_q | dut.alu_b_q | 32'(dut.alu_op_q)), 32'd0);
        end
        req = 2'b00;
        @(posedge clk); #1;
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v.gnt));
        check({tag, ".no_gnt_in_rsp"}, 32'(gnt), 32'd0);
        check({tag, ".result"}, rsp_result, v.res);
        check({tag, ".compout"}, 32'(rsp_compout), 32'(v.comp));
        check({tag, ".overflow"}, 32'(rsp_overflow), 32'(v.ovf));
        check({tag, ".err"}, 32'(rsp_err), 32'(v.err));
    endtask

    task automatic do_reset();
        req = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.gnt", 32'(gnt), 32'd0);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.result", rsp_result, 32'd0);
        check("reset.flags", {29'd0, rsp_compout, rsp_overflow, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t tbl[12];
    vec_t v;
    logic mprio;
    logic win;
    logic [31:0] last_res;

    initial begin
        // req op0 op1 u0 u1 a0 b0 a1 b1 | gnt res comp ovf err
        tbl[0]  = '{2'b01, ALU_ADD, ALU_AND, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0,
                    2'b01, 32'd12, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, ALU_AND, ALU_SUB, 1'b0, 1'b1, 32'd0, 32'd0, 32'd9, 32'd4,
                    2'b10, 32'd5, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'b01, ALU_ADD, ALU_AND, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0,
                    2'b01, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'b01, 3'b111, ALU_AND, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                    2'b01, 32'd0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{2'b10, ALU_AND, ALU_AND, 1'b0, 1'b1, 32'd0, 32'd0, 32'hF0F0_F0F0, 32'hFF00_FF00,
                    2'b10, 32'hF000_F000, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{2'b10, ALU_AND, ALU_NOR, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0,
                    2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'b01, ALU_XOR, ALU_AND, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 32'd0,
                    2'b01, 32'h5A5A_A5A5, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, ALU_SUB, ALU_AND, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'd0,
                    2'b01, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{2'b10, ALU_AND, ALU_OR, 1'b0, 1'b0, 32'd0, 32'd0, 32'h00FF_0000, 32'h0000_FF00,
                    2'b10, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{2'b01, 3'b011, ALU_AND, 1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0,
                    2'b01, 32'd0, 1'b0, 1'b0, 1'b1};
        // prio is 1 here (last owner 0), so contention goes to requester 1
        tbl[10] = '{2'b11, ALU_ADD, ALU_SUB, 1'b1, 1'b1, 32'd1, 32'd1, 32'd9, 32'd4,
                    2'b10, 32'd5, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'b11, ALU_ADD, ALU_SUB, 1'b1, 1'b1, 32'd1, 32'd1, 32'd9, 32'd4,
                    2'b01, 32'd2, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Contention held for 8 cycles from a fresh reset: 01,10,01,10
        do_reset();
        req = 2'b11; op0 = ALU_ADD; op1 = ALU_SUB; unsig0 = 1'b1; unsig1 = 1'b1;
        a0 = 32'd1; b0 = 32'd1; a1 = 32'd9; b1 = 32'd4;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c % 2 == 0) begin
                check($sformatf("cont.gnt%0d", c), 32'(gnt), ((c / 2) % 2 == 0) ? 32'd1 : 32'd2);
                check($sformatf("cont.rv%0d", c), 32'(rsp_valid), 32'd0);
            end else begin
                check($sformatf("cont.rv%0d", c), 32'(rsp_valid), ((c / 2) % 2 == 0) ? 32'd1 : 32'd2);
                check($sformatf("cont.gnt%0d", c), 32'(gnt), 32'd0);
                check($sformatf("cont.res%0d", c), rsp_result, ((c / 2) % 2 == 0) ? 32'd2 : 32'd5);
            end
        end
        req = 2'b00;

        // Idle for 10 cycles: nothing fires, response data holds
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("idle.gnt", 32'(gnt), 32'd0);
            check("idle.rsp_valid", 32'(rsp_valid), 32'd0);
            check("idle.hold", rsp_result, 32'd5);
        end

        // Reset during EXEC with prio=1 beforehand; prio must return to RR_INIT
        run_op(tbl[0], "pre_rst");
        req = 2'b10; op1 = ALU_ADD; a1 = 32'd3; b1 = 32'd4;
        @(posedge clk); #1;
        check("midrst.gnt", 32'(gnt), 32'd2);
        req = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.gnt0", 32'(gnt), 32'd0);
        check("midrst.result0", rsp_result, 32'd0);
        check("midrst.flags0", {29'd0, rsp_compout, rsp_overflow, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("midrst.no_rsp", 32'(rsp_valid), 32'd0);
        end
        req = 2'b11; op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd1;
        @(posedge clk); #1;
        check("midrst.first_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        @(posedge clk); #1;
        check("midrst.rsp", 32'(rsp_valid), 32'd1);

        // Randomized traffic against the reference model
        do_reset();
        mprio = 1'b0;
        last_res = 32'd0;
        for (int n = 0; n < 150; n++) begin
            v.req = 2'($urandom_range(1, 3));
            v.op0 = 3'($urandom_range(0, 7));
            v.op1 = 3'($urandom_range(0, 7));
            v.u0 = 1'($urandom_range(0, 1));
            v.u1 = 1'($urandom_range(0, 1));
            v.a0 = pick_operand(); v.b0 = pick_operand();
            v.a1 = pick_operand(); v.b1 = pick_operand();
            if (v.req == 2'b01) win = 1'b0;
            else if (v.req == 2'b10) win = 1'b1;
            else win = mprio;
            v.gnt = win ? 2'b10 : 2'b01;
            if (win) model(v.op1, v.u1, v.a1, v.b1, v.res, v.comp, v.ovf, v.err);
            else     model(v.op0, v.u0, v.a0, v.b0, v.res, v.comp, v.ovf, v.err);
            mprio = ~win;
            run_op(v, $sformatf("rnd%0d", n));
            last_res = v.res;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                check("rnd.idle_hold", rsp_result, last_res);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
